// File: rtl/imem_loader.sv
// imem_loader: assembles UART bytes (MSB first) into 32-bit words and writes them to instruction memory
module imem_loader #(
  parameter int len_addr = 32,
  parameter int len_data = 32,
  parameter int ram_depth = 2048,
  parameter logic [len_data-1:0] halt_word = {len_data{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                rx_done,
  input  logic [7:0]          rx_data,
  output logic                wr_en,
  output logic [len_addr-1:0] wr_addr,
  output logic [len_data-1:0] wr_data,
  output logic                busy,
  output logic                load_done,
  output logic                overflow
);
  localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  localparam logic [len_addr-1:0] last_addr = len_addr'(ram_depth - 1);
  logic [1:0] state, byte_cnt;
  logic [len_addr-1:0] word_cnt;
  logic [23:0] shreg;
  logic take;
  // bytes are accepted in WRITE too, so a full-rate stream loses nothing
  assign take = rx_done && (state == RECV || state == WRITE);
  assign wr_en = state == WRITE;
  assign busy = state == RECV || state == WRITE;
  assign load_done = state == DONE;
  // byte assembly, word addressing and load sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      shreg <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (take) begin
        shreg <= {shreg[15:0], rx_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
      case (state)
        IDLE, DONE: if (start) begin
          state <= RECV;
          word_cnt <= '0;
          byte_cnt <= '0;
          overflow <= 1'b0;
        end
        RECV: if (rx_done && byte_cnt == 2'd3) begin
          state <= WRITE;
          wr_addr <= word_cnt;
          wr_data <= {shreg, rx_data};
        end
        default: if (wr_data == halt_word) state <= DONE;
        else if (word_cnt == last_addr) begin
          state <= DONE;
          overflow <= 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
          state <= RECV;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized checks of imem_loader against a word-list reference model
module tb_imem_loader;
  localparam int RD = 4;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  logic clk = 0, rst_n = 0, start = 0, rx_done = 0;
  logic [7:0] rx_data = 0;
  logic wr_en, busy, load_done, overflow;
  logic [31:0] wr_addr, wr_data;
  int n_vec = 0, n_bad = 0;
  logic [63:0] got[$];

  imem_loader #(.ram_depth(RD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_done(rx_done), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .load_done(load_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en) got.push_back({wr_addr, wr_data});

  typedef struct packed {
    logic [5:0][31:0] w;
    logic [3:0] n;
    logic [1:0] gap;
    logic collide;
    logic mid;
    logic [3:0] exp_n;
    logic exp_ovf;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_wr_addr"}, wr_addr, 0);
    chk({nm, "_wr_data"}, wr_data, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, load_done, 0);
    chk({nm, "_ovf"}, overflow, 0);
  endtask

  task automatic run_load(input logic [5:0][31:0] w, input int n, input int gap,
                          input bit collide, input bit mid, output int nw, output bit ovf);
    logic [63:0] exp[$];
    logic [31:0] addr = 0;
    bit ended = 0;
    ovf = 0;
    for (int i = 0; i < n && !ended; i++) begin
      exp.push_back({addr, w[i]});
      if (w[i] == HALT) ended = 1;
      else if (addr == RD - 1) begin ended = 1; ovf = 1; end
      else addr++;
    end
    nw = exp.size();
    got.delete();
    @(negedge clk);
    start = 1;
    if (collide) begin rx_done = 1; rx_data = 8'h5A; end
    @(negedge clk);
    start = 0;
    rx_done = 0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", load_done, 0);
    chk("ovf_cleared", overflow, 0);
    for (int i = 0; i < n * 4; i++) begin
      rx_done = 1;
      rx_data = w[i / 4][31 - 8 * (i % 4) -: 8];
      if (mid && i == 2) start = 1;
      @(negedge clk);
      start = 0;
      rx_done = 0;
      repeat (gap) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("n_writes", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("addr[%0d]", i), got[i][63:32], exp[i][63:32]);
      chk($sformatf("data[%0d]", i), got[i][31:0], exp[i][31:0]);
    end
    chk("load_done", load_done, ended);
    chk("overflow", overflow, ovf);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    int nw;
    bit ovf;
    logic [5:0][31:0] w;
    int n;
    bit has_halt;
    tbl[0] = '{w: {128'h0, 32'hFFFFFFFF, 32'h12345678}, n: 2, gap: 1, collide: 0, mid: 0, exp_n: 2, exp_ovf: 0};
    tbl[1] = '{w: {64'h0, 32'hFFFFFFFF, 32'h99AABBCC, 32'h55667788, 32'h11223344}, n: 4, gap: 0, collide: 0, mid: 0, exp_n: 4, exp_ovf: 0};
    tbl[2] = '{w: {32'h0, 32'hE0E1E2E3, 32'hD0D1D2D3, 32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3}, n: 5, gap: 0, collide: 0, mid: 0, exp_n: 4, exp_ovf: 1};
    tbl[3] = '{w: {128'h0, 32'h12121212, 32'hFFFFFFFF}, n: 2, gap: 2, collide: 1, mid: 0, exp_n: 1, exp_ovf: 0};
    tbl[4] = '{w: {128'h0, 32'hFFFFFFFF, 32'h01020304}, n: 2, gap: 0, collide: 0, mid: 1, exp_n: 2, exp_ovf: 0};
    tbl[5] = '{w: {96'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE}, n: 3, gap: 1, collide: 1, mid: 0, exp_n: 3, exp_ovf: 0};
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1;
    for (int t = 0; t < 6; t++) begin
      run_load(tbl[t].w, int'(tbl[t].n), int'(tbl[t].gap), tbl[t].collide, tbl[t].mid, nw, ovf);
      chk($sformatf("tbl%0d_nw", t), nw, tbl[t].exp_n);
      chk($sformatf("tbl%0d_ovf", t), overflow, tbl[t].exp_ovf);
    end
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 2; i++) begin
      rx_done = 1; rx_data = 8'h30 + 8'(i);
      @(negedge clk);
      rx_done = 0;
    end
    #2 rst_n = 0;
    #2 chk_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      rx_done = 1; rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_done = 0;
    repeat (3) @(negedge clk);
    chk("idle_bytes_writes", got.size(), 0);
    chk("idle_bytes_busy", busy, 0);
    chk("idle_bytes_done", load_done, 0);
    run_load({128'h0, HALT, 32'hAABBCCDD}, 2, 0, 0, 0, nw, ovf);
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 6);
      w = '0;
      has_halt = 0;
      for (int i = 0; i < n; i++) begin
        w[i] = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
        if (w[i] == HALT && i < RD) has_halt = 1;
      end
      if (!has_halt && n < RD) w[n - 1] = HALT;
      run_load(w, n, $urandom_range(0, 2), 1'($urandom), 1'($urandom), nw, ovf);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
